video_pattern_gen: RTL and testbench
====================================

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  H_ACTIVE 720, visible pixels/line; H_FPORCH 16; H_SYNC 96; H_BPORCH 48 (pixels).
  V_ACTIVE 480, visible lines/frame; V_FPORCH 10; V_SYNC 2; V_BPORCH 33 (lines).
  COLOR_W 8, bits per colour channel; HSYNC_POL 0 / VSYNC_POL 0, asserted sync level (0 = active-low).
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk  in  1  pixel clock, sole clock.
  rst_n  in  1  asynchronous, active-low reset.
  enable  in  1  run timing; low = blank and hold.
  mode  in  2  pattern select: 0 colour bars, 1 checkerboard, 2 gradient, 3 solid white.
  hsync / vsync  out  1  sync at HSYNC_POL / VSYNC_POL when asserted.
  de  out  1  active-video flag.
  red / green / blue  out  COLOR_W  pixel colour.
  frame_start  out  1  one-cycle pulse on pixel (0,0).

Function
REQ-003 H_LIMIT = sum of H_* and V_LIMIT = sum of V_* SHALL each be <= 4096; counters are CNT_W = 12 bits.
REQ-004 h SHALL count 0..H_LIMIT-1 and wrap to 0; v SHALL increment when h wraps, and wrap to 0 after V_LIMIT-1.
REQ-005 de SHALL be high iff h < H_ACTIVE and v < V_ACTIVE.
REQ-006 hsync SHALL be asserted iff H_ACTIVE+H_FPORCH <= h < H_ACTIVE+H_FPORCH+H_SYNC.
REQ-007 vsync SHALL be asserted iff V_ACTIVE+V_FPORCH <= v < V_ACTIVE+V_FPORCH+V_SYNC, changing only at h = 0.
REQ-008 All outputs SHALL be registered: outputs in cycle n+1 reflect counter state (h,v) in cycle n (latency 1).
REQ-009 mode SHALL be sampled only when (h,v) = (0,0); mid-frame changes take effect at the next frame.
REQ-010 Mode 0: BAR_W = H_ACTIVE/8 and bar = x/BAR_W clipped to 7; colours in order white, yellow, cyan, green, magenta, red, blue, black; full scale is all ones.
REQ-011 Mode 1: all channels all-ones when px[4] XOR v[4] = 1, else zero.
REQ-012 Mode 2: all channels = px[COLOR_W-1:0]; mode 3: all channels all-ones.
REQ-013 red/green/blue SHALL be zero whenever de is low.
REQ-014 enable low SHALL force h = v = 0, de = 0, colours = 0, sync deasserted and frame_start = 0; the first enabled cycle starts at (0,0).

Reset
REQ-015 rst_n low SHALL immediately (asynchronously) clear h, v and the latched mode to 0, deassert hsync/vsync, and clear de, colours and frame_start.
REQ-016 Reset asserted mid-line or mid-frame SHALL abandon the frame; after release, timing restarts at (0,0) with a frame_start pulse.

Configuration
REQ-017 With VIDEO_PATTERN_GEN_SCROLL_EN defined: an 8-bit frame counter is reset to 0, increments on each frame_start and wraps at 255; px = (h + fcnt) truncated to CNT_W bits in modes 1 and 2.
REQ-018 Without VIDEO_PATTERN_GEN_SCROLL_EN: no frame counter exists and px = h; mode 0 is unaffected either way.

Structure
REQ-019 Package video_pattern_pkg SHALL hold CNT_W, the mode encodings and the eight-entry bar colour table (1 bit per channel, expanded to COLOR_W).
REQ-020 One sub-module, video_timing_counter, SHALL own h/v counting, de and raw sync; pattern and output registers live in the top.

Verification (defaults; H_LIMIT 880, V_LIMIT 525, frame 462000 cycles)
REQ-021 Release reset with enable=1 -> frame_start is seen 1 cycle later; hsync is low for 96 cycles starting 736 cycles after frame_start; hsync period is 880.
REQ-022 Run 2 frames -> vsync is low for 1760 cycles starting at line 490; frame_start period is 462000; de is high for 720-cycle bursts, 345600 cycles per frame.
REQ-023 Mode 0 -> RGB is FF/FF/FF at x = 0, FF/FF/00 at x = 90, 00/00/FF at x = 540, and 00/00/00 at x = 719 and during blanking.
REQ-024 Switch mode 0->2 at line 100 -> bars persist until the next frame_start, then red = x[7:0] (x = 200 gives C8).
REQ-025 Assert rst_n low mid-line 50 -> all outputs are inactive within the same cycle; after release, counting restarts at (0,0).
REQ-026 With VIDEO_PATTERN_GEN_SCROLL_EN, mode 2, fourth frame after reset -> red at x = 0 is 03; the counter wraps to 00 in frame 257.

Source files
------------

// File: rtl/video_pattern_pkg.sv
// Shared definitions for the video pattern generator.
//   CNT_W      : width of the horizontal / vertical position counters
//   mode_e     : pattern select encodings driven on the 'mode' port
//   BAR_RGB    : colour-bar table, one bit per channel {R,G,B}, entry 0 = leftmost bar
package video_pattern_pkg;

    localparam int CNT_W = 12;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_WHITE    = 2'd3
    } mode_e;

    // Packed array: element 7 is written first, element 0 (white) last.
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000,  // 7 black
        3'b001,  // 6 blue
        3'b100,  // 5 red
        3'b101,  // 4 magenta
        3'b010,  // 3 green
        3'b011,  // 2 cyan
        3'b110,  // 1 yellow
        3'b111   // 0 white
    };

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return BAR_RGB[idx];
    endfunction

endpackage

// File: rtl/video_pattern_gen_timing.sv
// video_timing_counter: raster position counters and raw (unregistered,
// active-high) timing decodes for the pattern generator.
//   i_clk, i_rst_n : pixel clock, asynchronous active-low reset
//   i_enable       : low holds the counters at (0,0)
//   o_h, o_v       : current pixel column / line
//   o_de           : position is inside the visible area
//   o_hsync/o_vsync: position is inside the sync pulse (active-high)
//   o_origin       : position is (0,0)
module video_timing_counter
    import video_pattern_pkg::*;
#(
    parameter int H_ACTIVE = 720,
    parameter int H_FPORCH = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BPORCH = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FPORCH = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BPORCH = 33
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_h,
    output logic [CNT_W-1:0] o_v,
    output logic             o_de,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_origin
);

    localparam int H_LIMIT = H_ACTIVE + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int V_LIMIT = V_ACTIVE + V_FPORCH + V_SYNC + V_BPORCH;
    localparam int CW1     = CNT_W + 1;

    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_LIMIT - 1);
    localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_LIMIT - 1);

    // One extra bit so a sync window ending exactly at 4096 still compares correctly.
    localparam logic [CNT_W:0] HA_END = CW1'(H_ACTIVE);
    localparam logic [CNT_W:0] HS_ON  = CW1'(H_ACTIVE + H_FPORCH);
    localparam logic [CNT_W:0] HS_OFF = CW1'(H_ACTIVE + H_FPORCH + H_SYNC);
    localparam logic [CNT_W:0] VA_END = CW1'(V_ACTIVE);
    localparam logic [CNT_W:0] VS_ON  = CW1'(V_ACTIVE + V_FPORCH);
    localparam logic [CNT_W:0] VS_OFF = CW1'(V_ACTIVE + V_FPORCH + V_SYNC);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic [CNT_W:0]   w_h_x;
    logic [CNT_W:0]   w_v_x;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (!i_enable) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_MAX) begin
            r_h <= '0;
            r_v <= (r_v == V_MAX) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign w_h_x = {1'b0, r_h};
    assign w_v_x = {1'b0, r_v};

    assign o_h      = r_h;
    assign o_v      = r_v;
    assign o_de     = (w_h_x < HA_END) && (w_v_x < VA_END);
    assign o_hsync  = (w_h_x >= HS_ON) && (w_h_x < HS_OFF);
    // v only moves when h wraps, so this decode changes only at h = 0.
    assign o_vsync  = (w_v_x >= VS_ON) && (w_v_x < VS_OFF);
    assign o_origin = (r_h == '0) && (r_v == '0);

endmodule

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: test-pattern video source with programmable raster timing.
//   clk, rst_n         : pixel clock, asynchronous active-low reset
//   enable             : low blanks all outputs and holds the raster at (0,0)
//   mode[1:0]          : 0 colour bars, 1 checkerboard, 2 gradient, 3 solid white;
//                        sampled at pixel (0,0) only
//   hsync, vsync       : sync outputs, asserted level set by HSYNC_POL / VSYNC_POL
//   de                 : active video
//   red, green, blue   : pixel colour, zero outside active video
//   frame_start        : one-cycle pulse on pixel (0,0)
// All outputs are registered and lag the raster counters by one cycle.
// Optional build macro VIDEO_PATTERN_GEN_SCROLL_EN adds an 8-bit frame counter
// that scrolls the checkerboard and gradient horizontally by one pixel per frame.
module video_pattern_gen
    import video_pattern_pkg::*;
#(
    parameter int H_ACTIVE  = 720,
    parameter int H_FPORCH  = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BPORCH  = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FPORCH  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BPORCH  = 33,
    parameter int COLOR_W   = 8,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               frame_start
);

    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);
    // Pattern coordinate needs bit 4 (checker) and COLOR_W bits (gradient).
    localparam int PX_W = (COLOR_W > 5) ? COLOR_W : 5;

    logic [CNT_W-1:0]   w_h;
    logic [CNT_W-1:0]   w_v;
    logic               w_de;
    logic               w_hs_raw;
    logic               w_vs_raw;
    logic               w_origin;
    logic [PX_W-1:0]    w_px;
    logic [CNT_W-1:0]   w_bar_div;
    logic [2:0]         w_bar_idx;
    logic [2:0]         w_bar_rgb;
    mode_e              w_mode;
    logic [COLOR_W-1:0] w_red;
    logic [COLOR_W-1:0] w_green;
    logic [COLOR_W-1:0] w_blue;

    mode_e              r_mode;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_de;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;
    logic               r_frame_start;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FPORCH (H_FPORCH),
        .H_SYNC   (H_SYNC),
        .H_BPORCH (H_BPORCH),
        .V_ACTIVE (V_ACTIVE),
        .V_FPORCH (V_FPORCH),
        .V_SYNC   (V_SYNC),
        .V_BPORCH (V_BPORCH)
    ) u_timing (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_enable (enable),
        .o_h      (w_h),
        .o_v      (w_v),
        .o_de     (w_de),
        .o_hsync  (w_hs_raw),
        .o_vsync  (w_vs_raw),
        .o_origin (w_origin)
    );

`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
    localparam int H_LIMIT = H_ACTIVE + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int V_LIMIT = V_ACTIVE + V_FPORCH + V_SYNC + V_BPORCH;
    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_LIMIT - 1);
    localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_LIMIT - 1);

    logic [7:0] r_fcnt;

    // Advancing on the last pixel of a frame keeps the offset constant across
    // a whole frame: frame N after reset renders with offset N-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt <= '0;
        end else if (enable && (w_h == H_MAX) && (w_v == V_MAX)) begin
            r_fcnt <= r_fcnt + 8'd1;
        end
    end

    assign w_px = PX_W'(w_h + CNT_W'(r_fcnt));
`else
    assign w_px = PX_W'(w_h);
`endif

    // The origin pixel already uses the incoming mode so a whole frame is uniform.
    assign w_mode    = w_origin ? mode_e'(mode) : r_mode;
    assign w_bar_div = w_h / BAR_W;
    assign w_bar_idx = (w_bar_div > CNT_W'(7)) ? 3'd7 : w_bar_div[2:0];
    assign w_bar_rgb = bar_rgb(w_bar_idx);

    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        case (w_mode)
            MODE_BARS: begin
                w_red   = {COLOR_W{w_bar_rgb[2]}};
                w_green = {COLOR_W{w_bar_rgb[1]}};
                w_blue  = {COLOR_W{w_bar_rgb[0]}};
            end
            MODE_CHECKER: begin
                w_red   = {COLOR_W{w_px[4] ^ w_v[4]}};
                w_green = {COLOR_W{w_px[4] ^ w_v[4]}};
                w_blue  = {COLOR_W{w_px[4] ^ w_v[4]}};
            end
            MODE_GRADIENT: begin
                w_red   = w_px[COLOR_W-1:0];
                w_green = w_px[COLOR_W-1:0];
                w_blue  = w_px[COLOR_W-1:0];
            end
            MODE_WHITE: begin
                w_red   = '1;
                w_green = '1;
                w_blue  = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_BARS;
        end else if (enable && w_origin) begin
            r_mode <= mode_e'(mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_de          <= 1'b0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_frame_start <= 1'b0;
        end else if (!enable) begin
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_de          <= 1'b0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hs_raw ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_vs_raw ? VSYNC_POL : ~VSYNC_POL;
            r_de          <= w_de;
            r_red         <= w_de ? w_red   : '0;
            r_green       <= w_de ? w_green : '0;
            r_blue        <= w_de ? w_blue  : '0;
            r_frame_start <= w_origin;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen using a reduced raster
// (80 x 48 total, 64 x 40 active, bar width 8) so several frames fit in a short run.
module tb_video_pattern_gen;

    localparam int HA    = 64;
    localparam int HF    = 4;
    localparam int HS    = 8;
    localparam int HB    = 4;
    localparam int HL    = HA + HF + HS + HB;  // 80
    localparam int VA    = 40;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 4;
    localparam int VL    = VA + VF + VS + VB;  // 48
    localparam int FRAME = HL * VL;            // 3840

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       frame_start;

    int total = 0;
    int bad   = 0;
    int pos;   // raster index (since last restart) whose pixel is on the outputs
    int fc;    // expected scroll offset of the frame on the outputs

    video_pattern_gen #(
        .H_ACTIVE  (HA),
        .H_FPORCH  (HF),
        .H_SYNC    (HS),
        .H_BPORCH  (HB),
        .V_ACTIVE  (VA),
        .V_FPORCH  (VF),
        .V_SYNC    (VS),
        .V_BPORCH  (VB),
        .COLOR_W   (8),
        .HSYNC_POL (1'b0),
        .VSYNC_POL (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mode        (mode),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pos++;
        if (pos > 0 && (pos % FRAME) == 0) fc++;
    endtask

    task automatic goto(input int f, input int v, input int h);
        int t;
        t = f * FRAME + v * HL + h;
        if (t < pos) begin
            total++;
            bad++;
            $error("FAIL goto: observed=%0d expected<=%0d", pos, t);
        end
        while (pos < t) tick();
    endtask

    function automatic logic [7:0] exp_px(input int h);
`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
        return 8'(h + fc);
`else
        return 8'(h);
`endif
    endfunction

    function automatic logic [31:0] exp_checker(input int h, input int v);
        logic [7:0] p;
        p = exp_px(h);
        return (p[4] ^ v[4]) ? 32'h00FF_FFFF : 32'h0;
    endfunction

    function automatic logic [31:0] rgb();
        return {8'h00, red, green, blue};
    endfunction

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        mode   = 2'd0;
        pos    = -1;
        fc     = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hsync", {31'd0, hsync}, 32'd1);
        chk("rst_vsync", {31'd0, vsync}, 32'd1);
        chk("rst_de",    {31'd0, de}, 32'd0);
        chk("rst_rgb",   rgb(), 32'h0);
        chk("rst_fs",    {31'd0, frame_start}, 32'd0);

        // Frame 0: colour bars
        @(negedge clk) rst_n = 1'b1;
        goto(0, 0, 0);
        chk("f0_fs",     {31'd0, frame_start}, 32'd1);
        chk("f0_de0",    {31'd0, de}, 32'd1);
        chk("bar_x0",    rgb(), 32'hFFFFFF);
        chk("f0_hs0",    {31'd0, hsync}, 32'd1);
        goto(0, 0, 8);
        chk("bar_x8",    rgb(), 32'hFFFF00);
        chk("fs_low",    {31'd0, frame_start}, 32'd0);
        goto(0, 0, 32);
        chk("bar_x32",   rgb(), 32'hFF00FF);
        goto(0, 0, 48);
        chk("bar_x48",   rgb(), 32'h0000FF);
        goto(0, 0, 63);
        chk("bar_x63",   rgb(), 32'h000000);
        chk("de_x63",    {31'd0, de}, 32'd1);
        goto(0, 0, 64);
        chk("de_x64",    {31'd0, de}, 32'd0);
        chk("rgb_blank", rgb(), 32'h0);
        goto(0, 0, 67);
        chk("hs_x67",    {31'd0, hsync}, 32'd1);
        goto(0, 0, 68);
        chk("hs_x68",    {31'd0, hsync}, 32'd0);
        goto(0, 0, 75);
        chk("hs_x75",    {31'd0, hsync}, 32'd0);
        goto(0, 0, 76);
        chk("hs_x76",    {31'd0, hsync}, 32'd1);
        goto(0, 1, 0);
        chk("l1_fs",     {31'd0, frame_start}, 32'd0);
        chk("l1_de",     {31'd0, de}, 32'd1);
        goto(0, 10, 0);
        mode = 2'd2;
        goto(0, 10, 20);
        chk("bars_hold", rgb(), 32'h00FFFF);
        goto(0, 40, 5);
        chk("vblank_de", {31'd0, de}, 32'd0);
        chk("vblank_rgb", rgb(), 32'h0);
        goto(0, 41, 79);
        chk("vs_l41",    {31'd0, vsync}, 32'd1);
        goto(0, 42, 0);
        chk("vs_l42",    {31'd0, vsync}, 32'd0);
        goto(0, 43, 79);
        chk("vs_l43",    {31'd0, vsync}, 32'd0);
        goto(0, 44, 0);
        chk("vs_l44",    {31'd0, vsync}, 32'd1);
        goto(0, 45, 70);
        chk("hs_vblank", {31'd0, hsync}, 32'd0);
        goto(0, 47, 79);
        chk("fs_last",   {31'd0, frame_start}, 32'd0);

        // Frame 1: gradient
        goto(1, 0, 0);
        chk("f1_fs",     {31'd0, frame_start}, 32'd1);
        chk("grad_x0",   rgb(), {8'h00, {3{exp_px(0)}}});
        goto(1, 0, 50);
        chk("grad_x50",  rgb(), {8'h00, {3{exp_px(50)}}});
        goto(1, 20, 63);
        chk("grad_x63",  rgb(), {8'h00, {3{exp_px(63)}}});
        mode = 2'd1;

        // Frame 2: checkerboard
        goto(2, 0, 15);
        chk("chk_15_0",  rgb(), exp_checker(15, 0));
        goto(2, 0, 16);
        chk("chk_16_0",  rgb(), exp_checker(16, 0));
        goto(2, 16, 0);
        chk("chk_0_16",  rgb(), exp_checker(0, 16));
        goto(2, 16, 16);
        chk("chk_16_16", rgb(), exp_checker(16, 16));
        mode = 2'd3;

        // Frame 3: solid white, then disable inside the vsync pulse
        goto(3, 5, 5);
        chk("white",     rgb(), 32'hFFFFFF);
        goto(3, 5, 70);
        chk("white_blank", rgb(), 32'h0);
        goto(3, 42, 70);
        chk("pre_dis_hs", {31'd0, hsync}, 32'd0);
        chk("pre_dis_vs", {31'd0, vsync}, 32'd0);
        enable = 1'b0;
        tick();
        chk("dis_hs",    {31'd0, hsync}, 32'd1);
        chk("dis_vs",    {31'd0, vsync}, 32'd1);
        chk("dis_de",    {31'd0, de}, 32'd0);
        chk("dis_fs",    {31'd0, frame_start}, 32'd0);
        repeat (3) tick();
        chk("dis_rgb",   rgb(), 32'h0);
        enable = 1'b1;
        pos = -1;
        tick();
        chk("en_fs",     {31'd0, frame_start}, 32'd1);
        chk("en_rgb",    rgb(), 32'hFFFFFF);
        goto(0, 0, 1);
        chk("en_fs_off", {31'd0, frame_start}, 32'd0);

        // Asynchronous reset mid-line
        goto(0, 20, 30);
        chk("pre_rst_de", {31'd0, de}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_de",   {31'd0, de}, 32'd0);
        chk("arst_rgb",  rgb(), 32'h0);
        chk("arst_hs",   {31'd0, hsync}, 32'd1);
        chk("arst_vs",   {31'd0, vsync}, 32'd1);
        chk("arst_fs",   {31'd0, frame_start}, 32'd0);
        mode = 2'd0;
        @(negedge clk) rst_n = 1'b1;
        pos = -1;
        fc  = 0;
        tick();
        chk("rst2_fs",   {31'd0, frame_start}, 32'd1);
        chk("rst2_x0",   rgb(), 32'hFFFFFF);
        goto(0, 0, 8);
        chk("rst2_x8",   rgb(), 32'hFFFF00);
        mode = 2'd2;

        // Fourth frame after reset in gradient mode
        goto(3, 0, 0);
        chk("f4_fs",     {31'd0, frame_start}, 32'd1);
        chk("f4_red_x0", {24'd0, red}, {24'd0, exp_px(0)});
        goto(3, 0, 60);
        chk("f4_red_x60", {24'd0, red}, {24'd0, exp_px(60)});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
